dutmem_rd_engine: RTL

//  Initiator for the dutmem single-port RAM interface (ce/we/addr/din/dout, 1-cycle registered read).

---
 rtl/dutmem_pkg.sv | 22 ++
 rtl/dutmem_rsp_fifo.sv | 73 +++++++
 rtl/dutmem_rd_engine.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dutmem_pkg.sv
// ============================================================================
// dutmem_pkg : shared state encoding and default widths for the dutmem engine
// Rev 1.0
// ============================================================================
`default_nettype none

package dutmem_pkg;

    localparam int DEF_DWIDTH    = 32;
    localparam int DEF_AWIDTH    = 10;
    localparam int DEF_LWIDTH    = 4;
    localparam int DEF_RSP_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_RBURST = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dutmem_rsp_fifo.sv
// ============================================================================
// dutmem_rsp_fifo : synchronous response FIFO, first-word fall-through
// Rev 1.0
// ============================================================================
`default_nettype none

module dutmem_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             w_empty;
    logic             w_pop;
    logic             w_write;
    logic             w_read;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // An empty FIFO presents the incoming word directly, so a push that is
    // popped in the same cycle never touches storage.
    assign w_empty = (count_q == '0);
    assign valid_o = !w_empty || push_i;
    assign data_o  = w_empty ? push_data_i : mem_q[rd_ptr_q];
    assign w_pop   = pop_i && valid_o;
    assign w_write = push_i && !(w_empty && w_pop);
    assign w_read  = w_pop && !w_empty;
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = w_write ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = w_read  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(w_write) - CW'(w_read);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dutmem_rd_engine.sv
// ============================================================================
// dutmem_rd_engine : write / burst-read initiator for the dutmem RAM port
// Optional power-on fill enabled by DUTMEM_INIT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module dutmem_rd_engine
    import dutmem_pkg::*;
#(
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int LWIDTH    = DEF_LWIDTH,
    parameter int RSP_DEPTH = DEF_RSP_DEPTH
`ifdef DUTMEM_INIT_EN
    ,
    parameter logic [DWIDTH-1:0] INIT_VAL = '0
`endif
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [LWIDTH-1:0] req_len_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_data_o,
    output logic              rsp_last_o,
    output logic              init_busy_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_din_o,
    input  logic [DWIDTH-1:0] mem_dout_i
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
`ifdef DUTMEM_INIT_EN
    localparam state_e RESET_STATE = ST_INIT;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LWIDTH-1:0] remain_q, remain_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;

    logic              w_fifo_valid;
    logic [DWIDTH:0]   w_fifo_data;
    logic [CW-1:0]     w_fifo_count;
    logic              w_pop;
    logic [CW:0]       w_credit_used;
    logic              w_credit_ok;
    logic              w_accept;
    logic              w_wr_acc;
    logic              w_rd_acc;

    assign w_accept = req_valid_i && rstn && (state_q == ST_IDLE);
    assign w_wr_acc = w_accept && req_we_i;
    assign w_rd_acc = w_accept && !req_we_i;

    // Credit counts words already queued plus the one still in the RAM
    // pipeline, less the word leaving this cycle.
    assign w_pop         = w_fifo_valid && rsp_ready_i;
    assign w_credit_used = (CW+1)'(w_fifo_count) + (CW+1)'(inflight_q) - (CW+1)'(w_pop);
    assign w_credit_ok   = (w_credit_used < (CW+1)'(RSP_DEPTH));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= RESET_STATE;
            cur_addr_q      <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            remain_q        <= remain_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        remain_d        = remain_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        case (state_q)
`ifdef DUTMEM_INIT_EN
            ST_INIT: begin
                cur_addr_d = cur_addr_q + AWIDTH'(1);
                if (&cur_addr_q) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                if (w_rd_acc) begin
                    cur_addr_d = req_addr_i;
                    remain_d   = req_len_i;
                    state_d    = ST_RBURST;
                end
            end
            ST_RBURST: begin
                if (w_credit_ok) begin
                    inflight_d      = 1'b1;
                    inflight_last_d = (remain_q == '0);
                    cur_addr_d      = cur_addr_q + AWIDTH'(1);
                    remain_d        = remain_q - LWIDTH'(1);
                    if (remain_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        init_busy_o = 1'b0;
        mem_ce_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_din_o   = '0;
        if (rstn) begin
            case (state_q)
`ifdef DUTMEM_INIT_EN
                ST_INIT: begin
                    init_busy_o = 1'b1;
                    mem_ce_o    = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = cur_addr_q;
                    mem_din_o   = INIT_VAL;
                end
`endif
                ST_IDLE: begin
                    req_ready_o = 1'b1;
                    if (w_wr_acc) begin
                        mem_ce_o   = 1'b1;
                        mem_we_o   = 1'b1;
                        mem_addr_o = req_addr_i;
                        mem_din_o  = req_wdata_i;
                    end
                end
                ST_RBURST: begin
                    if (w_credit_ok) begin
                        mem_ce_o   = 1'b1;
                        mem_addr_o = cur_addr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    dutmem_rsp_fifo #(
        .WIDTH (DWIDTH + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (inflight_q),
        .push_data_i ({mem_dout_i, inflight_last_q}),
        .pop_i       (rsp_ready_i),
        .valid_o     (w_fifo_valid),
        .data_o      (w_fifo_data),
        .count_o     (w_fifo_count)
    );

    assign rsp_valid_o = rstn && w_fifo_valid;
    assign rsp_data_o  = w_fifo_data[DWIDTH:1];
    assign rsp_last_o  = rstn && w_fifo_valid && w_fifo_data[0];

endmodule

`default_nettype wire
